// File: rtl/carcontrol_nios2_oci_trace_capture.sv
// Trace capture block: snapshots {dct_count, dct_buffer} into a small FIFO whenever the
// trace count advances (or reaches FULL_COUNT). A 4-state FSM gates capture and drains at end of test.
module carcontrol_nios2_oci_trace_capture #(
  parameter int DCT_WIDTH   = 30,
  parameter int COUNT_WIDTH = 4,
  parameter int DEPTH       = 16,
  parameter int MODE        = 0,
  parameter int FULL_COUNT  = 15
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               trace_enable,
  input  logic [DCT_WIDTH-1:0]               dct_buffer,
  input  logic [COUNT_WIDTH-1:0]             dct_count,
  input  logic                               test_ending,
  input  logic                               test_has_ended,
  input  logic                               rd_ready,
  output logic                               rd_valid,
  output logic [COUNT_WIDTH+DCT_WIDTH-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]             fill_level,
  output logic                               overflow,
  output logic [15:0]                        drop_count,
  output logic [1:0]                         state,
  output logic                               done
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = COUNT_WIDTH + DCT_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT                  r_state;
  stateT                  w_stateNext;
  logic [COUNT_WIDTH-1:0] r_prevCount;
  logic [AW-1:0]          r_wrPtr;
  logic [AW-1:0]          r_rdPtr;
  logic [AW:0]            r_fill;
  logic [AW:0]            w_fillNext;
  logic                   r_overflow;
  logic [15:0]            r_dropCount;
  logic [DW-1:0]          r_mem [DEPTH];

  logic w_event;
  logic w_capture;
  logic w_full;
  logic w_pop;
  logic w_write;
  logic w_drop;

  generate
    if (MODE == 0) begin : g_modeAdvance
      assign w_event = (dct_count != r_prevCount) && (dct_count != '0);
    end else begin : g_modeFull
      assign w_event = (dct_count == COUNT_WIDTH'(FULL_COUNT)) &&
                       (r_prevCount != COUNT_WIDTH'(FULL_COUNT));
    end
  endgenerate

  // A capture coinciding with test_ending is discarded outright, so it never counts as a drop.
  assign w_capture = (r_state == RUN) && w_event && !test_ending;
  assign w_full    = (r_fill == (AW+1)'(DEPTH));
  assign w_pop     = rd_valid && rd_ready;
  assign w_write   = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && w_full && !w_pop;

  always_comb begin
    w_fillNext = r_fill;
    case ({w_write, w_pop})
      2'b10:   w_fillNext = r_fill + 1'b1;
      2'b01:   w_fillNext = r_fill - 1'b1;
      default: w_fillNext = r_fill;
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:  if (trace_enable) w_stateNext = RUN;
      RUN: begin
        if (test_ending)        w_stateNext = DRAIN;
        else if (!trace_enable) w_stateNext = IDLE;
      end
      DRAIN: if (w_fillNext == '0) w_stateNext = DONE;
      DONE:  w_stateNext = DONE;
      default: w_stateNext = IDLE;
    endcase
    if (test_has_ended) w_stateNext = DONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_prevCount <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_fill      <= '0;
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_prevCount <= dct_count;
      r_fill      <= w_fillNext;
      if (w_write) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)   r_rdPtr <= r_rdPtr + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropCount != 16'hFFFF) r_dropCount <= r_dropCount + 16'd1;
      end
    end
  end

  // Storage is not reset; contents are meaningless whenever rd_valid is low.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wrPtr] <= {dct_count, dct_buffer};
  end

  assign rd_data    = r_mem[r_rdPtr];
  assign rd_valid   = (r_fill != '0);
  assign fill_level = r_fill;
  assign overflow   = r_overflow;
  assign drop_count = r_dropCount;
  assign state      = r_state;
  assign done       = (r_state == DONE);

endmodule

// File: tb/tb_carcontrol_nios2_oci_trace_capture.sv
// Directed bench for the trace capture block: a MODE 0 instance exercises the FIFO/FSM,
// and a MODE 1 instance checks full-count-only capture.
module tb_carcontrol_nios2_oci_trace_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trace_enable = 1'b0;
  logic [29:0] dct_buffer = '0;
  logic [3:0]  dct_count = '0;
  logic        test_ending = 1'b0;
  logic        test_has_ended = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [33:0] rd_data;
  logic [4:0]  fill_level;
  logic        overflow;
  logic [15:0] drop_count;
  logic [1:0]  state;
  logic        done;

  logic        te1 = 1'b0;
  logic [29:0] buf1 = '0;
  logic [3:0]  cnt1 = '0;
  logic        rdReady1 = 1'b0;
  logic        rdValid1;
  logic [33:0] rdData1;
  logic [4:0]  fill1;
  logic        overflow1;
  logic [15:0] drop1;
  logic [1:0]  state1;
  logic        done1;

  int nErr = 0;
  int nChk = 0;
  int lastCnt = 0;

  always #5 clk = ~clk;

  carcontrol_nios2_oci_trace_capture #(.MODE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .trace_enable(trace_enable),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .fill_level(fill_level), .overflow(overflow),
    .drop_count(drop_count), .state(state), .done(done)
  );

  carcontrol_nios2_oci_trace_capture #(.MODE(1), .FULL_COUNT(15)) u1 (
    .clk(clk), .reset_n(reset_n), .trace_enable(te1),
    .dct_buffer(buf1), .dct_count(cnt1), .test_ending(1'b0),
    .test_has_ended(1'b0), .rd_ready(rdReady1), .rd_valid(rdValid1),
    .rd_data(rdData1), .fill_level(fill1), .overflow(overflow1),
    .drop_count(drop1), .state(state1), .done(done1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a count guaranteed to differ from the previous one and be nonzero.
  task automatic cap(input logic [29:0] b);
    lastCnt = (lastCnt % 15) + 1;
    dct_count = 4'(lastCnt);
    dct_buffer = b;
    step();
  endtask

  task automatic doReset();
    trace_enable = 1'b0;
    rd_ready = 1'b0;
    test_ending = 1'b0;
    test_has_ended = 1'b0;
    dct_count = '0;
    lastCnt = 0;
    reset_n = 1'b0;
    #5;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    if (state !== 2'd0)      begin $display("[TB] FAIL reset_state got %0d want 0", state); nErr++; end
    nChk++;
    if (fill_level !== 5'd0) begin $display("[TB] FAIL reset_fill got %0d want 0", fill_level); nErr++; end
    nChk++;
    if (rd_valid !== 1'b0)   begin $display("[TB] FAIL reset_valid got %b want 0", rd_valid); nErr++; end
    nChk++;
    if (overflow !== 1'b0 || drop_count !== 16'd0 || done !== 1'b0) begin
      $display("[TB] FAIL reset_flags got ovf=%b drop=%0d done=%b want 0/0/0", overflow, drop_count, done);
      nErr++;
    end
    nChk++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    trace_enable = 1'b1;
    dct_count = 4'd0;
    step();
    if (state !== 2'd1) begin $display("[TB] FAIL basic_run got %0d want 1", state); nErr++; end
    nChk++;
    dct_count = 4'd1; dct_buffer = 30'h1; step();
    if (rd_valid !== 1'b1) begin $display("[TB] FAIL basic_latency got %b want 1", rd_valid); nErr++; end
    nChk++;
    dct_count = 4'd2; dct_buffer = 30'h2; step();
    dct_count = 4'd3; dct_buffer = 30'h3; step();
    lastCnt = 3;
    if (fill_level !== 5'd3) begin $display("[TB] FAIL basic_fill got %0d want 3", fill_level); nErr++; end
    nChk++;
    rd_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      if (rd_data !== {4'(i), 30'(i)}) begin
        $display("[TB] FAIL basic_data%0d got %h want %h", i, rd_data, {4'(i), 30'(i)});
        nErr++;
      end
      nChk++;
      step();
    end
    rd_ready = 1'b0;
    if (fill_level !== 5'd0 || rd_valid !== 1'b0) begin
      $display("[TB] FAIL basic_empty got fill=%0d valid=%b want 0/0", fill_level, rd_valid);
      nErr++;
    end
    nChk++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 18; i++) cap(30'(100 + i));
    if (fill_level !== 5'd16) begin $display("[TB] FAIL ovf_fill got %0d want 16", fill_level); nErr++; end
    nChk++;
    if (overflow !== 1'b1 || drop_count !== 16'd2) begin
      $display("[TB] FAIL ovf_drop got ovf=%b drop=%0d want 1/2", overflow, drop_count);
      nErr++;
    end
    nChk++;
    if (rd_data !== {4'd4, 30'd100}) begin $display("[TB] FAIL ovf_head got %h want %h", rd_data, {4'd4, 30'd100}); nErr++; end
    nChk++;
    rd_ready = 1'b1;
    cap(30'd500);
    rd_ready = 1'b0;
    if (fill_level !== 5'd16 || drop_count !== 16'd2) begin
      $display("[TB] FAIL back_to_back got fill=%0d drop=%0d want 16/2", fill_level, drop_count);
      nErr++;
    end
    nChk++;
    if (rd_data !== {4'd5, 30'd101}) begin $display("[TB] FAIL b2b_head got %h want %h", rd_data, {4'd5, 30'd101}); nErr++; end
    nChk++;
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    rd_ready = 1'b0;
    if (fill_level !== 5'd0) begin $display("[TB] FAIL ovf_drain got %0d want 0", fill_level); nErr++; end
    nChk++;
  endtask

  task automatic test_drain_done();
    for (int i = 0; i < 4; i++) cap(30'(200 + i));
    test_ending = 1'b1;
    cap(30'd299);
    test_ending = 1'b0;
    if (state !== 2'd2 || fill_level !== 5'd4 || drop_count !== 16'd2) begin
      $display("[TB] FAIL drain_enter got st=%0d fill=%0d drop=%0d want 2/4/2", state, fill_level, drop_count);
      nErr++;
    end
    nChk++;
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    if (state !== 2'd2 || fill_level !== 5'd1) begin
      $display("[TB] FAIL drain_mid got st=%0d fill=%0d want 2/1", state, fill_level);
      nErr++;
    end
    nChk++;
    step();
    rd_ready = 1'b0;
    if (state !== 2'd3 || done !== 1'b1 || fill_level !== 5'd0) begin
      $display("[TB] FAIL drain_done got st=%0d done=%b fill=%0d want 3/1/0", state, done, fill_level);
      nErr++;
    end
    nChk++;
    cap(30'd7);
    cap(30'd8);
    if (state !== 2'd3 || fill_level !== 5'd0) begin
      $display("[TB] FAIL done_ignore got st=%0d fill=%0d want 3/0", state, fill_level);
      nErr++;
    end
    nChk++;
  endtask

  task automatic test_has_ended_force();
    doReset();
    trace_enable = 1'b1;
    step();
    for (int i = 0; i < 5; i++) cap(30'(300 + i));
    test_has_ended = 1'b1;
    step();
    test_has_ended = 1'b0;
    if (state !== 2'd3 || done !== 1'b1 || fill_level !== 5'd5) begin
      $display("[TB] FAIL ended_state got st=%0d done=%b fill=%0d want 3/1/5", state, done, fill_level);
      nErr++;
    end
    nChk++;
    if (rd_data !== {4'd1, 30'd300}) begin $display("[TB] FAIL ended_head got %h want %h", rd_data, {4'd1, 30'd300}); nErr++; end
    nChk++;
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    if (rd_data !== {4'd2, 30'd301} || fill_level !== 5'd4) begin
      $display("[TB] FAIL ended_pop got %h fill=%0d want %h/4", rd_data, fill_level, {4'd2, 30'd301});
      nErr++;
    end
    nChk++;
  endtask

  task automatic test_reset_mid();
    doReset();
    trace_enable = 1'b1;
    step();
    for (int i = 0; i < 17; i++) cap(30'(400 + i));
    rd_ready = 1'b1;
    for (int i = 0; i < 9; i++) step();
    rd_ready = 1'b0;
    if (fill_level !== 5'd7 || overflow !== 1'b1 || drop_count !== 16'd1) begin
      $display("[TB] FAIL mid_setup got fill=%0d ovf=%b drop=%0d want 7/1/1", fill_level, overflow, drop_count);
      nErr++;
    end
    nChk++;
    reset_n = 1'b0;
    #1;
    if (state !== 2'd0 || fill_level !== 5'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 16'd0) begin
      $display("[TB] FAIL mid_reset got st=%0d fill=%0d valid=%b ovf=%b drop=%0d want all 0",
               state, fill_level, rd_valid, overflow, drop_count);
      nErr++;
    end
    nChk++;
    #3;
    reset_n = 1'b1;
    trace_enable = 1'b0;
    step();
  endtask

  task automatic test_mode1();
    te1 = 1'b1;
    cnt1 = 4'd0;
    step();
    for (int c = 1; c <= 15; c++) begin
      cnt1 = 4'(c); buf1 = 30'(c); step();
    end
    for (int i = 0; i < 4; i++) step();
    cnt1 = 4'd0; step();
    for (int c = 1; c <= 15; c++) begin
      cnt1 = 4'(c); buf1 = 30'h100 | 30'(c); step();
    end
    if (fill1 !== 5'd2) begin $display("[TB] FAIL mode1_fill got %0d want 2", fill1); nErr++; end
    nChk++;
    if (rdData1 !== {4'hF, 30'hF}) begin $display("[TB] FAIL mode1_first got %h want %h", rdData1, {4'hF, 30'hF}); nErr++; end
    nChk++;
    rdReady1 = 1'b1;
    step();
    rdReady1 = 1'b0;
    if (rdData1 !== {4'hF, 30'h10F}) begin $display("[TB] FAIL mode1_second got %h want %h", rdData1, {4'hF, 30'h10F}); nErr++; end
    nChk++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_drain_done();
    test_has_ended_force();
    test_reset_mid();
    test_mode1();
    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule

// File: doc/carcontrol_nios2_oci_trace_capture.md
CARCONTROL_NIOS2_OCI_TRACE_CAPTURE -- requirements
Module: carControl_nios2_oci_trace_capture

Interface
REQ-001 Parameter DCT_WIDTH, default 30: width of the data-trace buffer word.
REQ-002 Parameter COUNT_WIDTH, default 4: width of the trace entry count.
REQ-003 Parameter DEPTH, default 16, power of two >= 2: capture FIFO entries.
REQ-004 Parameter MODE, default 0: 0 = capture every count advance; 1 = capture only on reaching FULL_COUNT.
REQ-005 Parameter FULL_COUNT, default 15: count value treated as "buffer full" in MODE 1.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-008 trace_enable  input  1  level; arms capture from IDLE.
REQ-009 dct_buffer  input  DCT_WIDTH  data-trace buffer contents.
REQ-010 dct_count  input  COUNT_WIDTH  valid entries in dct_buffer.
REQ-011 test_ending  input  1  pulse/level; stop capturing, drain FIFO.
REQ-012 test_has_ended  input  1  level; forces immediate end of test.
REQ-013 rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-014 rd_valid  output  1  rd_data holds an unread entry.
REQ-015 rd_data  output  COUNT_WIDTH+DCT_WIDTH  {captured dct_count, captured dct_buffer}.
REQ-016 fill_level  output  clog2(DEPTH)+1  entries currently stored, 0..DEPTH.
REQ-017 overflow  output  1  sticky: at least one capture dropped.
REQ-018 drop_count  output  16  dropped captures, saturating.
REQ-019 state  output  2  FSM state: IDLE=0, RUN=1, DRAIN=2, DONE=3.
REQ-020 done  output  1  high exactly when state == DONE.

Function
REQ-021 Register prev_count <= dct_count every cycle, in all states.
REQ-022 Capture event, MODE 0: dct_count != prev_count and dct_count != 0; MODE 1: dct_count == FULL_COUNT and prev_count != FULL_COUNT.
REQ-023 Capture events act only in RUN; ignored in IDLE, DRAIN, DONE.
REQ-024 Write: on capture event with FIFO not full, store {dct_count, dct_buffer} sampled that cycle.
REQ-025 Read: pop when rd_valid && rd_ready; rd_data presents head entry combinationally from storage; rd_valid = fill_level != 0.
REQ-026 Write-to-rd_valid latency: 1 cycle (entry visible the cycle after the capture edge).
REQ-027 Full with simultaneous pop and capture: both performed, fill_level unchanged, no drop.
REQ-028 Full, capture, no pop: entry dropped, overflow set to 1, drop_count += 1, saturating at 16'hFFFF.
REQ-029 Empty, no pop possible; rd_ready while rd_valid=0 has no effect.
REQ-030 Read/write pointers wrap modulo DEPTH; fill_level tracks occupancy exactly.
REQ-031 FSM IDLE -> RUN when trace_enable=1.
REQ-032 FSM RUN -> DRAIN when test_ending=1; capture event that same cycle is discarded (not counted as drop).
REQ-033 FSM DRAIN -> DONE when fill_level == 0 (including fill_level reaching 0 by pop that cycle's next edge).
REQ-034 FSM any state -> DONE when test_has_ended=1; priority over all other transitions; FIFO contents retained and still readable.
REQ-035 DONE held until reset; trace_enable and test_ending ignored in DONE.
REQ-036 RUN -> IDLE when trace_enable deasserts without test_ending; FIFO contents retained.
REQ-037 overflow and drop_count clear only on reset.

Reset
REQ-038 reset_n=0 asynchronously: state=IDLE, pointers=0, fill_level=0, rd_valid=0, overflow=0, drop_count=0, prev_count=0, done=0.
REQ-039 Reset mid-operation discards all FIFO contents; rd_data is don't-care while rd_valid=0.
REQ-040 Outputs leave reset values only on the first rising clk after reset_n rises.

Verification
REQ-041 MODE 0, trace_enable=1, dct_count 0->1->2->3 with buffers 0x0000001,0x0000002,0x0000003, rd_ready=0 -> fill_level=3, rd_data={4'h1,30'h1}; assert rd_ready 3 cycles -> entries in order, fill_level=0.
REQ-042 DEPTH=16, 18 captures, rd_ready=0 -> fill_level=16, overflow=1, drop_count=2; then full with simultaneous pop+capture -> fill_level stays 16, drop_count stays 2.
REQ-043 MODE 1, FULL_COUNT=15, dct_count ramps 0..15, holds 15 for 5 cycles, returns 0, ramps again -> exactly 2 entries, both with count field 15.
REQ-044 RUN with 4 entries, test_ending pulse -> state=DRAIN; 4 pops -> state=DONE, done=1 next edge; later captures ignored.
REQ-045 RUN with 5 entries, test_has_ended=1 -> state=DONE next edge, fill_level=5, entries still readable.
REQ-046 reset_n pulsed low mid-RUN with 7 entries and overflow=1 -> immediately state=0, fill_level=0, rd_valid=0, overflow=0, drop_count=0.
